phase_frame_ctrl: RTL and testbench

Double-buffered phase/enable frame controller for the transducer PWM array. Collects per-channel phase and enable writes from the host-command path into a shadow bank and commits the whole frame atomically at a PWM period boundary, so every channel switches phase on the same carrier cycle. Sits in the PWM clock domain between the command receiver/phase-parse path and the per-channel `pwm` instances.

---
 rtl/phase_frame_pkg.sv | 11 +
 rtl/phase_frame_ctrl_if.sv | 18 +
 rtl/period_watchdog.sv | 25 ++
 rtl/phase_frame_ctrl.sv | 95 +++++++++
 tb/tb_phase_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_frame_pkg.sv
// phase_frame_pkg: FSM states, err bit positions and channel-index width helper
// shared by the phase frame controller and its bus interface.
package phase_frame_pkg;
    typedef enum logic [1:0] {IDLE, PENDING, SWAP} state_t;
    localparam int ERR_COMMIT = 0;
    localparam int ERR_RANGE = 1;
    // Leaves room for one code above the last channel so out-of-range writes can be expressed.
    function automatic int ch_idx_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/phase_frame_ctrl_if.sv
// phase_frame_ctrl_if: host-side shadow write / commit bus of the phase frame controller.
interface phase_frame_ctrl_if
    import phase_frame_pkg::*;
#(
    parameter int NUM_CHANNELS = 128,
    parameter int CLK_CNT_W = 8
);
    localparam int CH_W = ch_idx_w(NUM_CHANNELS);
    logic wr_valid;
    logic wr_ready;
    logic [CH_W-1:0] wr_channel;
    logic [CLK_CNT_W-1:0] wr_phase;
    logic wr_en;
    logic commit;
    logic commit_pending;
    modport master(output wr_valid, wr_channel, wr_phase, wr_en, commit, input wr_ready, commit_pending);
    modport slave(input wr_valid, wr_channel, wr_phase, wr_en, commit, output wr_ready, commit_pending);
endinterface

// File: rtl/period_watchdog.sv
// period_watchdog: counts PWM periods since the last clear and trips after PERIODS of them.
module period_watchdog #(
    parameter int PERIODS = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic clear,
    output logic trip
);
    localparam int CNT_W = $clog2(PERIODS + 1);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            trip <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
            trip <= 1'b0;
        end else if (tick && !trip) begin
            cnt <= cnt + 1'b1;
            trip <= cnt == CNT_W'(PERIODS - 1);
        end
    end
endmodule

// File: rtl/phase_frame_ctrl.sv
// phase_frame_ctrl: double-buffered phase/enable frame, swapped atomically at a PWM period boundary.
// Define PHASE_FRAME_WDT_EN to add the period watchdog that blanks enables when commits stop.
module phase_frame_ctrl
    import phase_frame_pkg::*;
#(
    parameter int NUM_CHANNELS = 128,
    parameter int CLK_CNT_W = 8,
    parameter int CLK_CNT_MAX = 255
`ifdef PHASE_FRAME_WDT_EN
    , parameter int WDT_PERIODS = 1024
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [CLK_CNT_W-1:0] pwm_cnt,
    phase_frame_ctrl_if.slave wr,
    output logic [NUM_CHANNELS*CLK_CNT_W-1:0] phases,
    output logic [NUM_CHANNELS-1:0] ch_en,
    output logic swapped,
    output logic [7:0] frame_id,
    output logic [1:0] err,
    output logic wdt_trip
);
    localparam int CH_W = ch_idx_w(NUM_CHANNELS);
    localparam int IDX_W = $clog2(NUM_CHANNELS);
    state_t state, state_d;
    logic [NUM_CHANNELS*CLK_CNT_W-1:0] sh_ph;
    logic [NUM_CHANNELS-1:0] sh_en;
    logic [NUM_CHANNELS-1:0] act_en;
    logic [IDX_W-1:0] idx;
    logic boundary, wr_fire, in_range;
    assign boundary = pwm_cnt == CLK_CNT_W'(CLK_CNT_MAX);
    assign wr_fire = wr.wr_valid && wr.wr_ready;
    assign in_range = wr.wr_channel < CH_W'(NUM_CHANNELS);
    assign idx = wr.wr_channel[IDX_W-1:0];
    always_comb begin
        state_d = state;
        wr.wr_ready = 1'b0;
        wr.commit_pending = 1'b0;
        swapped = 1'b0;
        case (state)
            IDLE: begin
                wr.wr_ready = 1'b1;
                state_d = wr.commit ? PENDING : IDLE;
            end
            PENDING: begin
                wr.commit_pending = 1'b1;
                state_d = boundary ? SWAP : PENDING;
            end
            default: begin
                swapped = 1'b1;
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_ph <= '0;
            sh_en <= '0;
            phases <= '0;
            act_en <= '0;
            frame_id <= '0;
            err <= '0;
        end else begin
            if (wr_fire && in_range) begin
                sh_ph[int'(idx)*CLK_CNT_W +: CLK_CNT_W] <= wr.wr_phase;
                sh_en[idx] <= wr.wr_en;
            end
            if (swapped) begin
                phases <= sh_ph;
                act_en <= sh_en;
                frame_id <= frame_id + 8'd1;
            end
            if (wr.commit && state != IDLE) err[ERR_COMMIT] <= 1'b1;
            if (wr_fire && !in_range) err[ERR_RANGE] <= 1'b1;
        end
    end
`ifdef PHASE_FRAME_WDT_EN
    period_watchdog #(.PERIODS(WDT_PERIODS)) u_wdt (
        .clk(clk),
        .rst_n(rst_n),
        .tick(boundary),
        .clear(swapped),
        .trip(wdt_trip)
    );
`else
    assign wdt_trip = 1'b0;
`endif
    // Phases stay loaded while tripped; only the enables are blanked.
    assign ch_en = act_en & ~{NUM_CHANNELS{wdt_trip}};
endmodule

// File: tb/tb_phase_frame_ctrl.sv
// tb_phase_frame_ctrl: scoreboard bench; each commit pushes the expected frame, each swap pops and checks it.
module tb_phase_frame_ctrl;
    localparam int NCH = 128;
    localparam int CW = 8;
    typedef struct packed {
        logic [NCH*CW-1:0] ph;
        logic [NCH-1:0] en;
        logic [7:0] fid;
    } frame_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [CW-1:0] pwm_cnt = '0;
    logic [NCH*CW-1:0] phases;
    logic [NCH-1:0] ch_en;
    logic swapped, wdt_trip;
    logic [7:0] frame_id;
    logic [1:0] err;
    frame_t sb[$];
    frame_t exp_f;
    logic [NCH*CW-1:0] m_ph = '0;
    logic [NCH-1:0] m_en = '0;
    logic [7:0] m_fid = '0;
    int n_checks = 0;
    int n_fail = 0;
    int cyc;

    phase_frame_ctrl_if #(.NUM_CHANNELS(NCH), .CLK_CNT_W(CW)) bus();

    phase_frame_ctrl #(
        .NUM_CHANNELS(NCH),
        .CLK_CNT_W(CW),
        .CLK_CNT_MAX(255)
`ifdef PHASE_FRAME_WDT_EN
        , .WDT_PERIODS(4)
`endif
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pwm_cnt(pwm_cnt),
        .wr(bus),
        .phases(phases),
        .ch_en(ch_en),
        .swapped(swapped),
        .frame_id(frame_id),
        .err(err),
        .wdt_trip(wdt_trip)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        pwm_cnt = pwm_cnt + 1'b1;
    endtask

    task automatic run_to(input logic [CW-1:0] v);
        for (int i = 0; i < 300 && pwm_cnt != v; i++) step();
    endtask

    task automatic drive_write(input int ch, input logic [CW-1:0] ph, input logic en, input bit acc);
        bus.wr_valid = 1'b1;
        bus.wr_channel = 8'(ch);
        bus.wr_phase = ph;
        bus.wr_en = en;
        step();
        bus.wr_valid = 1'b0;
        if (acc && ch < NCH) begin
            m_ph[ch*CW +: CW] = ph;
            m_en[ch] = en;
        end
    endtask

    task automatic push_frame();
        m_fid = m_fid + 8'd1;
        sb.push_back('{ph: m_ph, en: m_en, fid: m_fid});
    endtask

    task automatic commit_at(input logic [CW-1:0] v);
        run_to(v);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        push_frame();
    endtask

    task automatic wait_swap(input int max, output int c);
        c = 0;
        while (swapped !== 1'b1 && c < max) begin
            step();
            c++;
        end
    endtask

    task automatic get_exp(output frame_t e);
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
    endtask

    function automatic string diag(frame_t e);
        for (int i = 0; i < NCH; i++)
            if (phases[i*CW +: CW] !== e.ph[i*CW +: CW] || ch_en[i] !== e.en[i])
                return $sformatf("ch %0d got phase %h en %b, expected phase %h en %b",
                                 i, phases[i*CW +: CW], ch_en[i], e.ph[i*CW +: CW], e.en[i]);
        return $sformatf("got frame_id %0d, expected %0d", frame_id, e.fid);
    endfunction

    task automatic test_reset();
        step();
        rst_n = 1'b0;
        #2;
        n_checks++; if (phases !== '0) begin n_fail++; $display("FAIL reset_phases got nonzero want 0"); end
        n_checks++; if (ch_en !== '0) begin n_fail++; $display("FAIL reset_ch_en got %h want 0", ch_en); end
        n_checks++; if (swapped !== 1'b0) begin n_fail++; $display("FAIL reset_swapped got %b want 0", swapped); end
        n_checks++; if (frame_id !== 8'd0) begin n_fail++; $display("FAIL reset_frame_id got %0d want 0", frame_id); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL reset_err got %b want 00", err); end
        n_checks++; if (wdt_trip !== 1'b0) begin n_fail++; $display("FAIL reset_wdt_trip got %b want 0", wdt_trip); end
        n_checks++; if (bus.commit_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", bus.commit_pending); end
        step();
        step();
        rst_n = 1'b1;
        step();
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", bus.wr_ready); end
    endtask

    task automatic test_basic();
        drive_write(3, 8'h40, 1'b1, 1'b1);
        commit_at(8'd10);
        n_checks++; if (bus.commit_pending !== 1'b1) begin n_fail++; $display("FAIL basic_pending got %b want 1", bus.commit_pending); end
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL basic_wr_ready got %b want 0", bus.wr_ready); end
        wait_swap(600, cyc);
        n_checks++; if (swapped !== 1'b1 || pwm_cnt !== 8'd0) begin n_fail++; $display("FAIL basic_swap_point got swapped %b at pwm_cnt %0d want 1 at 0", swapped, pwm_cnt); end
        n_checks++; if (bus.commit_pending !== 1'b0) begin n_fail++; $display("FAIL basic_pending_in_swap got %b want 0", bus.commit_pending); end
        step();
        n_checks++; if (swapped !== 1'b0) begin n_fail++; $display("FAIL basic_swapped_width got %b want 0", swapped); end
        get_exp(exp_f);
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL basic_frame %s", diag(exp_f)); end
        n_checks++; if (phases[3*CW +: CW] !== 8'h40 || ch_en[3] !== 1'b1 || frame_id !== 8'd1) begin n_fail++; $display("FAIL basic_ch3 got phase %h en %b id %0d want 40 1 1", phases[3*CW +: CW], ch_en[3], frame_id); end
    endtask

    task automatic test_commit_at_max();
        drive_write(7, 8'h77, 1'b1, 1'b1);
        commit_at(8'd255);
        wait_swap(600, cyc);
        n_checks++; if (cyc !== 256) begin n_fail++; $display("FAIL max_commit_latency got %0d cycles want 256", cyc); end
        step();
        get_exp(exp_f);
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL max_commit_frame %s", diag(exp_f)); end
    endtask

    task automatic test_write_commit_same();
        run_to(8'd20);
        bus.commit = 1'b1;
        drive_write(5, 8'h10, 1'b1, 1'b1);
        bus.commit = 1'b0;
        push_frame();
        n_checks++; if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL held_wr_ready got %b want 0", bus.wr_ready); end
        drive_write(5, 8'h99, 1'b0, 1'b0);
        drive_write(9, 8'h55, 1'b1, 1'b0);
        wait_swap(600, cyc);
        step();
        get_exp(exp_f);
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL same_cycle_frame %s", diag(exp_f)); end
        n_checks++; if (phases[5*CW +: CW] !== 8'h10 || ch_en[5] !== 1'b1) begin n_fail++; $display("FAIL same_cycle_ch5 got %h %b want 10 1", phases[5*CW +: CW], ch_en[5]); end
    endtask

    task automatic test_errors();
        commit_at(8'd30);
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL err_before got %b want 00", err); end
        run_to(8'd40);
        bus.commit = 1'b1;
        step();
        bus.commit = 1'b0;
        n_checks++; if (err !== 2'b01) begin n_fail++; $display("FAIL err_double_commit got %b want 01", err); end
        wait_swap(600, cyc);
        step();
        get_exp(exp_f);
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL double_commit_frame %s", diag(exp_f)); end
        wait_swap(300, cyc);
        n_checks++; if (swapped !== 1'b0) begin n_fail++; $display("FAIL double_commit_extra_swap got %b want 0", swapped); end
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL range_wr_ready got %b want 1", bus.wr_ready); end
        drive_write(200, 8'hAB, 1'b1, 1'b1);
        n_checks++; if (err !== 2'b11) begin n_fail++; $display("FAIL err_range got %b want 11", err); end
        commit_at(pwm_cnt);
        wait_swap(600, cyc);
        step();
        get_exp(exp_f);
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL range_frame %s", diag(exp_f)); end
    endtask

    task automatic test_reset_mid_pending();
        drive_write(9, 8'h33, 1'b1, 1'b1);
        commit_at(8'd100);
        repeat (5) step();
        n_checks++; if (bus.commit_pending !== 1'b1) begin n_fail++; $display("FAIL midrst_pending got %b want 1", bus.commit_pending); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (phases !== '0 || ch_en !== '0) begin n_fail++; $display("FAIL midrst_banks got ch_en %h want 0", ch_en); end
        n_checks++; if ({frame_id, err, swapped, wdt_trip, bus.commit_pending} !== 13'd0) begin n_fail++; $display("FAIL midrst_status got id %0d err %b sw %b wdt %b pend %b want all 0", frame_id, err, swapped, wdt_trip, bus.commit_pending); end
        step();
        rst_n = 1'b1;
        m_ph = '0;
        m_en = '0;
        m_fid = '0;
        sb.delete();
        wait_swap(300, cyc);
        n_checks++; if (swapped !== 1'b0) begin n_fail++; $display("FAIL midrst_stale_swap got %b want 0", swapped); end
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_wr_ready got %b want 1", bus.wr_ready); end
        commit_at(pwm_cnt);
        wait_swap(600, cyc);
        step();
        get_exp(exp_f);
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL midrst_shadow_cleared %s", diag(exp_f)); end
    endtask

`ifdef PHASE_FRAME_WDT_EN
    task automatic test_wdt();
        drive_write(1, 8'h05, 1'b1, 1'b1);
        commit_at(pwm_cnt);
        wait_swap(600, cyc);
        step();
        get_exp(exp_f);
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL wdt_armed_frame %s", diag(exp_f)); end
        repeat (3) begin
            run_to(8'd255);
            step();
        end
        n_checks++; if (wdt_trip !== 1'b0 || ch_en[1] !== 1'b1) begin n_fail++; $display("FAIL wdt_early got trip %b en %b want 0 1", wdt_trip, ch_en[1]); end
        run_to(8'd255);
        step();
        n_checks++; if (wdt_trip !== 1'b1 || ch_en !== '0) begin n_fail++; $display("FAIL wdt_trip got trip %b ch_en %h want 1 0", wdt_trip, ch_en); end
        n_checks++; if (phases[1*CW +: CW] !== 8'h05) begin n_fail++; $display("FAIL wdt_phase_kept got %h want 05", phases[1*CW +: CW]); end
        commit_at(pwm_cnt);
        wait_swap(600, cyc);
        step();
        get_exp(exp_f);
        n_checks++; if (wdt_trip !== 1'b0) begin n_fail++; $display("FAIL wdt_clear got %b want 0", wdt_trip); end
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL wdt_restore_frame %s", diag(exp_f)); end
    endtask
`else
    task automatic test_no_wdt();
        drive_write(1, 8'h05, 1'b1, 1'b1);
        commit_at(pwm_cnt);
        wait_swap(600, cyc);
        step();
        get_exp(exp_f);
        n_checks++; if ({phases, ch_en, frame_id} !== exp_f) begin n_fail++; $display("FAIL nowdt_frame %s", diag(exp_f)); end
        repeat (5 * 256) step();
        n_checks++; if (wdt_trip !== 1'b0 || ch_en !== m_en) begin n_fail++; $display("FAIL nowdt_idle got trip %b ch_en %h want 0 %h", wdt_trip, ch_en, m_en); end
    endtask
`endif

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_channel = '0;
        bus.wr_phase = '0;
        bus.wr_en = 1'b0;
        bus.commit = 1'b0;
        test_reset();
        test_basic();
        test_commit_at_max();
        test_write_commit_same();
        test_errors();
        test_reset_mid_pending();
`ifdef PHASE_FRAME_WDT_EN
        test_wdt();
`else
        test_no_wdt();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got no end of test within 1 ms simulated");
        $fatal(1, "timeout");
    end
endmodule
